scheduler: RTL and testbench

SCHEDULER -- requirements
Module: scheduler

---
 rtl/scheduler_pkg.sv | 40 ++++
 rtl/scheduler_core_tracker.sv | 39 +++
 rtl/scheduler.sv | 189 ++++++++++++++++++
 tb/tb_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scheduler_pkg.sv
// Shared definitions for the task scheduler: state encoding, task header
// field positions and the pointer/frame arithmetic helpers.
package scheduler_pkg;

   // Scheduler state encoding
   typedef logic [2:0] sched_state_t;
   localparam sched_state_t ST_IDLE  = 3'd0;
   localparam sched_state_t ST_FETCH = 3'd1;
   localparam sched_state_t ST_WAIT  = 3'd2;
   localparam sched_state_t ST_SEND  = 3'd3;
   localparam sched_state_t ST_DONE  = 3'd4;

   // Fields of the ctrl word (first header word)
   localparam int FRAMES_LSB = 0;
   localparam int FRAMES_MSB = 5;
   localparam int BLOCK_BIT  = 6;
   localparam int EXCL_BIT   = 7;

   // Header word offsets relative to the task pointer
   localparam int HDR_CTRL_OFS  = 0;
   localparam int HDR_MASK_OFS  = 1;
   localparam int HDR_COMPL_OFS = 2;

   // Pointer is one bit wider than the word address so running off the end
   // of program memory is visible; frame indices wrap over the 64 frames.
   localparam int PTR_W           = 11;
   localparam int FRAME_IDX_W     = 6;
   localparam int FRAME_WORDS_LOG = 4;

   // Pointer of the task that follows a task of (frames_m1 + 1) frames
   function automatic logic [PTR_W-1:0] next_task_ptr(
      input logic [PTR_W-1:0]       ptr,
      input logic [FRAME_IDX_W-1:0] frames_m1
   );
      logic [PTR_W-1:0] span;
      span = (PTR_W'(frames_m1) + PTR_W'(1)) << FRAME_WORDS_LOG;
      return ptr + span;
   endfunction

endpackage

// File: rtl/scheduler_core_tracker.sv
// Tracks which cores are still working on a dispatched task. A core becomes
// busy when a task is handed to it and is released by a rising edge of its
// ready line; availability combines the ready line with the busy bit.
module scheduler_core_tracker
   import scheduler_pkg::*;
#(
   parameter int CORE_NUM = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [CORE_NUM-1:0] core_ready,
   input  logic [CORE_NUM-1:0] set_mask,
   output logic [CORE_NUM-1:0] avail
);

   logic [CORE_NUM-1:0] busy;
   logic [CORE_NUM-1:0] ready_prev;
   logic [CORE_NUM-1:0] ready_rise;

   assign ready_rise = core_ready & ~ready_prev;
   assign avail      = core_ready & ~busy;

   // Busy bits: a new dispatch takes priority over a release in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_prev <= '0;
         busy       <= '0;
      end else begin
         ready_prev <= core_ready;
         if (clear) begin
            busy <= '0;
         end else begin
            busy <= (busy & ~ready_rise) | set_mask;
         end
      end
   end

endmodule

// File: rtl/scheduler.sv
// Task scheduler: walks the program memory task by task, waits until the
// target cores can take a task, then streams its frames to them one frame
// per accepted cycle and marks the cores busy once the last frame is taken.
module scheduler
   import scheduler_pkg::*;
#(
   parameter int DATA_DEPTH     = 1024,
   parameter int R0_DATA_SIZE   = 128,
   parameter int CTRL_DATA_SIZE = 48,
   parameter int INSTR_SIZE     = 16,
   parameter int FRAME_SIZE     = 256,
   parameter int FRAME_NUM      = 64,
   parameter int CORE_NUM       = 16,
   parameter int BUS_TO_CORE    = 16,
   parameter int R0_DEPTH       = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             prog_loading,
   input  logic [DATA_DEPTH*INSTR_SIZE-1:0] data_frames_in,
   input  logic [CORE_NUM-1:0]              core_ready,
   input  logic [CORE_NUM-1:0]              core_reading,
   output logic [FRAME_SIZE-1:0]            frame_out,
   output logic                             frame_being_sent,
   output logic                             frame_last,
   output logic [BUS_TO_CORE-1:0]           core_mask_out,
   output logic                             sched_done
);

   localparam int AW = $clog2(DATA_DEPTH);

   logic [INSTR_SIZE-1:0]     word_arr [DATA_DEPTH];
   logic [FRAME_SIZE-1:0]     frame_arr [FRAME_NUM];

   sched_state_t              state;
   logic [PTR_W-1:0]          task_ptr;
   logic [CTRL_DATA_SIZE-1:0] task_hdr;
   logic [FRAME_IDX_W-1:0]    frame_k;
   logic                      block_pending;
   logic [CORE_NUM-1:0]       block_mask;

   logic [INSTR_SIZE-1:0]     mem_ctrl;
   logic [INSTR_SIZE-1:0]     mem_mask;
   logic [INSTR_SIZE-1:0]     mem_compl;
   logic                      ptr_overflow;
   logic [FRAME_IDX_W-1:0]    task_frames_m1;
   logic [CORE_NUM-1:0]       task_mask;
   logic                      task_block;
   logic                      task_excl;
   logic [FRAME_IDX_W-1:0]    frame_base;
   logic [FRAME_IDX_W-1:0]    next_k;
   logic [FRAME_IDX_W-1:0]    frame_sel;
   logic                      launch_ok;
   logic                      accept;
   logic                      last_frame;
   logic                      send_done;
   logic [CORE_NUM-1:0]       avail;
   logic [CORE_NUM-1:0]       busy_set;
   logic                      unused_ok;

   // Word and frame views of the packed program memory
   for (genvar w = 0; w < DATA_DEPTH; w++) begin : g_word
      assign word_arr[w] = data_frames_in[w*INSTR_SIZE +: INSTR_SIZE];
   end
   for (genvar f = 0; f < FRAME_NUM; f++) begin : g_frame
      assign frame_arr[f] = data_frames_in[f*FRAME_SIZE +: FRAME_SIZE];
   end

   // Header words at the current pointer; pointer is frame aligned so the
   // offsets never carry out of the frame.
   assign mem_ctrl     = word_arr[task_ptr[AW-1:0] + AW'(HDR_CTRL_OFS)];
   assign mem_mask     = word_arr[task_ptr[AW-1:0] + AW'(HDR_MASK_OFS)];
   assign mem_compl    = word_arr[task_ptr[AW-1:0] + AW'(HDR_COMPL_OFS)];
   assign ptr_overflow = task_ptr >= PTR_W'(DATA_DEPTH);

   assign task_frames_m1 = task_hdr[FRAMES_MSB:FRAMES_LSB];
   assign task_block     = task_hdr[BLOCK_BIT];
   assign task_excl      = task_hdr[EXCL_BIT];
   assign task_mask      = task_hdr[HDR_MASK_OFS*INSTR_SIZE +: CORE_NUM];
   assign frame_base     = task_ptr[FRAME_WORDS_LOG +: FRAME_IDX_W];

   // Frame to load into the output register: frame 0 on launch, k+1 on advance
   assign next_k    = (state == ST_SEND) ? frame_k + FRAME_IDX_W'(1) : '0;
   assign frame_sel = frame_base + next_k;

   // Launch needs the task's cores free, every core free for an exclusive
   // task, and the cores of a preceding blocking task back as well.
   assign launch_ok = ((avail & task_mask) == task_mask)
                   && (!task_excl || (&avail))
                   && (!block_pending || ((avail & block_mask) == block_mask));

   assign accept     = (core_reading & task_mask) == task_mask;
   assign last_frame = frame_k == task_frames_m1;
   assign send_done  = (state == ST_SEND) && accept && last_frame && !prog_loading;
   assign busy_set   = send_done ? task_mask : '0;

   // Header bits that are carried but not acted upon
   assign unused_ok = &{1'b0, task_hdr[CTRL_DATA_SIZE-1:2*INSTR_SIZE],
                        task_hdr[INSTR_SIZE-1:EXCL_BIT+1],
                        (R0_DATA_SIZE != 0), (R0_DEPTH != 0)};

   scheduler_core_tracker #(
      .CORE_NUM (CORE_NUM)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .clear      (prog_loading),
      .core_ready (core_ready),
      .set_mask   (busy_set),
      .avail      (avail)
   );

   // Scheduler FSM with registered frame outputs; loading aborts everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         task_ptr         <= '0;
         task_hdr         <= '0;
         frame_k          <= '0;
         block_pending    <= 1'b0;
         block_mask       <= '0;
         frame_out        <= '0;
         frame_being_sent <= 1'b0;
         frame_last       <= 1'b0;
         core_mask_out    <= '0;
         sched_done       <= 1'b0;
      end else if (prog_loading) begin
         state            <= ST_IDLE;
         task_ptr         <= '0;
         frame_k          <= '0;
         frame_out        <= '0;
         frame_being_sent <= 1'b0;
         frame_last       <= 1'b0;
         core_mask_out    <= '0;
         sched_done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               task_ptr <= '0;
               state    <= ST_FETCH;
            end
            ST_FETCH: begin
               if (ptr_overflow || (mem_mask == '0)) begin
                  state      <= ST_DONE;
                  sched_done <= 1'b1;
               end else begin
                  task_hdr <= {mem_compl, mem_mask, mem_ctrl};
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (launch_ok) begin
                  state            <= ST_SEND;
                  frame_k          <= '0;
                  frame_out        <= frame_arr[frame_sel];
                  frame_being_sent <= 1'b1;
                  frame_last       <= (task_frames_m1 == '0);
                  core_mask_out    <= BUS_TO_CORE'(task_mask);
               end
            end
            ST_SEND: begin
               if (accept) begin
                  if (last_frame) begin
                     block_pending    <= task_block;
                     block_mask       <= task_mask;
                     task_ptr         <= next_task_ptr(task_ptr, task_frames_m1);
                     state            <= ST_FETCH;
                     frame_out        <= '0;
                     frame_being_sent <= 1'b0;
                     frame_last       <= 1'b0;
                     core_mask_out    <= '0;
                  end else begin
                     frame_k    <= next_k;
                     frame_out  <= frame_arr[frame_sel];
                     frame_last <= (next_k == task_frames_m1);
                  end
               end
            end
            ST_DONE: begin
               sched_done <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scheduler.sv
// Self-checking bench for the scheduler: directed task programs plus random
// programs and random core handshakes, compared every cycle against a
// task-level model of the scheduling rules.
module tb_scheduler;

   localparam int DEPTH = 1024;
   localparam int W     = 16;
   localparam int FS    = 256;
   localparam int NF    = 64;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_WAIT  = 2;
   localparam int M_SEND  = 3;
   localparam int M_DONE  = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 prog_loading;
   logic [DEPTH*W-1:0]   mem;
   logic [15:0]          core_ready;
   logic [15:0]          core_reading;
   logic [FS-1:0]        frame_out;
   logic                 frame_being_sent;
   logic                 frame_last;
   logic [15:0]          core_mask_out;
   logic                 sched_done;

   int n_compared   = 0;
   int n_mismatched = 0;
   int sent_frames  = 0;

   // Task-level model state
   int          m_mode;
   int          m_p;
   int          m_k;
   int          m_nfr;
   logic [15:0] m_mask;
   logic        m_block;
   logic        m_excl;
   logic [15:0] m_busy;
   logic [15:0] m_prev_ready;
   logic        m_blk_pend;
   logic [15:0] m_blk_mask;

   always #5 clk = ~clk;

   scheduler dut (
      .clk              (clk),
      .reset            (reset),
      .prog_loading     (prog_loading),
      .data_frames_in   (mem),
      .core_ready       (core_ready),
      .core_reading     (core_reading),
      .frame_out        (frame_out),
      .frame_being_sent (frame_being_sent),
      .frame_last       (frame_last),
      .core_mask_out    (core_mask_out),
      .sched_done       (sched_done)
   );

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] get_word(input int a);
      return mem[a*W +: W];
   endfunction

   task automatic set_word(input int a, input logic [15:0] v);
      mem[a*W +: W] = v;
   endtask

   // One clock edge of the scheduling rules applied to the model
   task automatic model_step(input logic rst, input logic ld, input logic [15:0] rdy, input logic [15:0] rd);
      logic [15:0] rise;
      logic [15:0] avail;
      logic [15:0] set;
      logic [15:0] c;
      bit          ok;
      if (rst) begin
         m_mode = M_IDLE; m_p = 0; m_k = 0; m_busy = '0;
         m_prev_ready = '0; m_blk_pend = 1'b0; m_blk_mask = '0;
         return;
      end
      rise  = rdy & ~m_prev_ready;
      avail = rdy & ~m_busy;
      set   = '0;
      if (ld) begin
         m_mode = M_IDLE; m_p = 0; m_busy = '0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_p = 0; m_mode = M_FETCH;
            end
            M_FETCH: begin
               if (m_p >= DEPTH || get_word(m_p + 1) == 16'h0) begin
                  m_mode = M_DONE;
               end else begin
                  c       = get_word(m_p);
                  m_nfr   = int'(c[5:0]) + 1;
                  m_block = c[6];
                  m_excl  = c[7];
                  m_mask  = get_word(m_p + 1);
                  m_mode  = M_WAIT;
               end
            end
            M_WAIT: begin
               ok = ((avail & m_mask) == m_mask);
               if (m_excl && avail != 16'hffff) ok = 0;
               if (m_blk_pend && (avail & m_blk_mask) != m_blk_mask) ok = 0;
               if (ok) begin
                  m_mode = M_SEND; m_k = 0;
               end
            end
            M_SEND: begin
               if ((rd & m_mask) == m_mask) begin
                  if (m_k == m_nfr - 1) begin
                     set        = m_mask;
                     m_blk_pend = m_block;
                     m_blk_mask = m_mask;
                     m_p        = m_p + 16 * m_nfr;
                     m_mode     = M_FETCH;
                  end else begin
                     m_k++;
                  end
               end
            end
            default: ;
         endcase
         m_busy = (m_busy & ~rise) | set;
      end
      m_prev_ready = rdy;
   endtask

   // Compare every DUT output with what the model says it should show
   task automatic compare_all();
      logic          sending;
      logic [FS-1:0] exp_frame;
      sending   = (m_mode == M_SEND);
      exp_frame = '0;
      if (sending) exp_frame = mem[(((m_p / 16) + m_k) % NF) * FS +: FS];
      checkOutput("frame_being_sent", 256'(frame_being_sent), 256'(sending));
      checkOutput("frame_out", 256'(frame_out), 256'(exp_frame));
      checkOutput("frame_last", 256'(frame_last), 256'(sending && (m_k == m_nfr - 1)));
      checkOutput("core_mask_out", 256'(core_mask_out), 256'(sending ? m_mask : 16'h0));
      checkOutput("sched_done", 256'(sched_done), 256'(m_mode == M_DONE));
   endtask

   task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] rdy,
                                input logic [15:0] rd, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = rst; prog_loading = ld; core_ready = rdy; core_reading = rd;
         if (!rst && !ld && frame_being_sent && ((rd & core_mask_out) == core_mask_out))
            sent_frames++;
         @(posedge clk);
         model_step(rst, ld, rdy, rd);
         #1;
         compare_all();
      end
   endtask

   task automatic wait_model_send(input logic [15:0] rdy, input logic [15:0] rd, input int limit);
      int i;
      i = 0;
      while (m_mode != M_SEND && i < limit) begin
         applyStimulus(1'b0, 1'b0, rdy, rd, 1);
         i++;
      end
      checkOutput("reach_send", 256'(m_mode), 256'(M_SEND));
   endtask

   task automatic build_random_program();
      int          p;
      int          nfr;
      logic [15:0] ctrl;
      logic [15:0] mask;
      for (int a = 0; a < DEPTH; a++) set_word(a, 16'($urandom));
      p = 0;
      while (p < DEPTH) begin
         nfr  = $urandom_range(1, 6);
         ctrl = (16'($urandom) & 16'hff00) | 16'(nfr - 1);
         if ($urandom_range(0, 3) == 0) ctrl[6] = 1'b1; else ctrl[6] = 1'b0;
         if ($urandom_range(0, 5) == 0) ctrl[7] = 1'b1; else ctrl[7] = 1'b0;
         mask = (16'($urandom) & 16'($urandom)) | (16'h1 << $urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) mask = 16'h0;
         set_word(p, ctrl);
         set_word(p + 1, mask);
         set_word(p + 2, mask);
         if (mask == 16'h0) break;
         p = p + 16 * nfr;
      end
   endtask

   initial begin
      reset = 1'b1; prog_loading = 1'b1; core_ready = 16'hffff; core_reading = 16'hffff;
      for (int a = 0; a < DEPTH; a++) mem[a*W +: W] = 16'($urandom);
      set_word(0, 16'h0043);   set_word(1, 16'h000f);   set_word(2, 16'h000f);
      set_word(64, 16'h0003);  set_word(65, 16'h00f0);  set_word(66, 16'h00f0);
      set_word(128, 16'h0007); set_word(129, 16'h00f0); set_word(130, 16'h00f0);
      set_word(256, 16'h008f); set_word(257, 16'h0f00); set_word(258, 16'h0f00);
      set_word(512, 16'h0000); set_word(513, 16'h0000);

      // Directed program: blocking, busy, exclusive tasks and a stalled read
      applyStimulus(1'b1, 1'b1, 16'hffff, 16'hffff, 3);
      applyStimulus(1'b0, 1'b1, 16'hffff, 16'hffff, 2);
      sent_frames = 0;
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 12);
      applyStimulus(1'b0, 1'b0, 16'hfff0, 16'hffff, 3);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 12);
      applyStimulus(1'b0, 1'b0, 16'hff0f, 16'hffff, 3);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 16);
      applyStimulus(1'b0, 1'b0, 16'h7fff, 16'hffff, 4);
      applyStimulus(1'b0, 1'b0, 16'hff0f, 16'hffff, 2);
      wait_model_send(16'hffff, 16'hffff, 10);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 2);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hfeff, 3);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 30);
      checkOutput("done_after_program", 256'(sched_done), 256'(1));
      checkOutput("frames_delivered", 256'(sent_frames), 256'(32));

      // Abort in the middle of a send, then restart from the first task
      applyStimulus(1'b0, 1'b1, 16'hffff, 16'hffff, 2);
      wait_model_send(16'hffff, 16'hffff, 10);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 2);
      applyStimulus(1'b0, 1'b1, 16'hffff, 16'hffff, 1);
      checkOutput("abort_sent", 256'(frame_being_sent), 256'(0));
      applyStimulus(1'b0, 1'b1, 16'hffff, 16'hffff, 1);
      applyStimulus(1'b0, 1'b0, 16'hffff, 16'hffff, 15);

      // Random programs with random handshakes, loads and resets
      for (int it = 0; it < 6; it++) begin
         applyStimulus(1'b1, 1'b0, 16'hffff, 16'hffff, 1);
         build_random_program();
         applyStimulus(1'b1, 1'b0, 16'hffff, 16'hffff, 2);
         for (int c = 0; c < 400; c++) begin
            applyStimulus(1'b0 | ($urandom_range(0, 499) == 0),
                          1'b0 | ($urandom_range(0, 299) == 0),
                          ~(16'($urandom) & 16'($urandom) & 16'($urandom)),
                          ~(16'($urandom) & 16'($urandom)), 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
